// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection scheduler: state encoding,
// approach indices, signal-head bit positions and head encodings.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALL_RED  = 3'd0,
    GREEN_ST = 3'd1,
    GREEN_RT = 3'd2,
    YELLOW   = 3'd3
  } state_t;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Bit positions inside one 8-bit signal head
  localparam int SIG_ST_RED  = 0;
  localparam int SIG_RT_RED  = 1;
  localparam int SIG_YEL     = 2;
  localparam int SIG_ST_GRN  = 3;
  localparam int SIG_RT_GRN  = 4;
  localparam int SIG_LT_GRN  = 5;
  localparam int SIG_PED_RED = 6;
  localparam int SIG_PED_GRN = 7;

  // Head encodings built from the bit positions above
  localparam logic [7:0] SIG_RED    = 8'((1 << SIG_ST_RED) | (1 << SIG_RT_RED) | (1 << SIG_PED_RED));  // 0x43
  localparam logic [7:0] SIG_ST     = 8'((1 << SIG_RT_RED) | (1 << SIG_ST_GRN) | (1 << SIG_LT_GRN)
                                         | (1 << SIG_PED_RED));                                     // 0x6A
  localparam logic [7:0] SIG_ST_PED = 8'((1 << SIG_RT_RED) | (1 << SIG_ST_GRN) | (1 << SIG_LT_GRN)
                                         | (1 << SIG_PED_GRN));                                     // 0xAA
  localparam logic [7:0] SIG_RT     = 8'((1 << SIG_ST_RED) | (1 << SIG_RT_GRN) | (1 << SIG_LT_GRN)
                                         | (1 << SIG_PED_RED));                                     // 0x71
  localparam logic [7:0] SIG_YEL_V  = 8'((1 << SIG_RT_RED) | (1 << SIG_YEL) | (1 << SIG_PED_RED));    // 0x46

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set request at or after ptr,
// wrapping past index 3 back to 0.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);

  // Walk offsets high to low so the smallest offset from ptr wins last
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        grant = ptr + 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase scheduler: round-robin service of four approaches
// through straight / right-turn / yellow / all-red, with latched pedestrian
// requests. Define EMERGENCY_PREEMPT_EN to enable emergency preemption;
// otherwise emg_req is ignored.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int ST_TIME  = 10,
  parameter int RT_TIME  = 5,
  parameter int YEL_TIME = 3,
  parameter int AR_TIME  = 1,
  parameter int CNT_W    = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] veh_req,
  input  logic [3:0] ped_req,
  input  logic [3:0] emg_req,
  output logic [7:0] north_sgnl_out,
  output logic [7:0] south_sgnl_out,
  output logic [7:0] east_sgnl_out,
  output logic [7:0] west_sgnl_out,
  output logic [1:0] active_dir,
  output logic [2:0] phase,
  output logic [3:0] ped_ack
);

  localparam logic [CNT_W-1:0] ST_LD  = CNT_W'(ST_TIME - 1);
  localparam logic [CNT_W-1:0] RT_LD  = CNT_W'(RT_TIME - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YEL_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LD  = CNT_W'(AR_TIME - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       rr_q, rr_d;
  logic [3:0]       ped_pend_q, ped_pend_d, ped_clr;
  logic             ped_flag_q, ped_flag_d;
  logic             enter_st;

  logic [3:0]       cand;
  logic [1:0]       rr_gnt;
  logic             rr_vld;
  logic [1:0]       emg_gnt;
  logic             emg_vld, preempt, extend;

  logic [3:0][7:0]  sig_d, sig_q;
  logic [3:0]       ack_d, ack_q;

  assign cand = veh_req | ped_pend_q;

  rr_arbiter4 u_rr (
    .req  (cand),
    .ptr  (rr_q),
    .grant(rr_gnt),
    .valid(rr_vld)
  );

`ifdef EMERGENCY_PREEMPT_EN
  // Fixed-priority emergency pick: pointer pinned at north gives lowest index
  rr_arbiter4 u_emg (
    .req  (emg_req),
    .ptr  (DIR_N),
    .grant(emg_gnt),
    .valid(emg_vld)
  );
  assign preempt = |(emg_req & ~dir_onehot(dir_q));
  assign extend  = emg_req[dir_q];
`else
  logic unused_emg;
  assign unused_emg = ^emg_req;
  assign emg_gnt    = DIR_N;
  assign emg_vld    = 1'b0;
  assign preempt    = 1'b0;
  assign extend     = 1'b0;
`endif

  // State, phase counter, served approach and arbitration pointer
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ALL_RED;
      cnt_q      <= AR_LD;
      dir_q      <= DIR_N;
      rr_q       <= DIR_N;
      ped_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      rr_q       <= rr_d;
      ped_flag_q <= ped_flag_d;
    end
  end

  // Next-state: each phase lasts its TIME; ALL_RED re-arbitrates while idle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    rr_d       = rr_q;
    ped_flag_d = ped_flag_q;
    enter_st   = 1'b0;
    case (state_q)
      ALL_RED: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (emg_vld || rr_vld) begin
          state_d    = GREEN_ST;
          cnt_d      = ST_LD;
          enter_st   = 1'b1;
          dir_d      = emg_vld ? emg_gnt : rr_gnt;
          // emergency grants leave the round-robin order untouched
          if (!emg_vld) rr_d = rr_gnt + 2'd1;
          ped_flag_d = ped_pend_q[dir_d];
        end
        // no candidate: counter stays at zero and we retry next cycle
      end
      GREEN_ST: begin
        if (preempt) begin
          state_d = YELLOW;
          cnt_d   = YEL_LD;
        end else if (extend) begin
          cnt_d = cnt_q;
        end else if (cnt_q == '0) begin
          state_d = GREEN_RT;
          cnt_d   = RT_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GREEN_RT: begin
        if (preempt || cnt_q == '0) begin
          state_d = YELLOW;
          cnt_d   = YEL_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      YELLOW: begin
        if (cnt_q == '0) begin
          state_d = ALL_RED;
          cnt_d   = AR_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ALL_RED;
        cnt_d   = AR_LD;
      end
    endcase
  end

  // A fresh press survives a same-cycle service; a repeat press is absorbed
  assign ped_clr    = enter_st ? dir_onehot(dir_d) : 4'b0000;
  assign ped_pend_d = (ped_pend_q & ~ped_clr) | (ped_req & ~ped_pend_q);

  // Pending pedestrian requests
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ped_pend_q <= '0;
    else        ped_pend_q <= ped_pend_d;
  end

  // Output decode from next state so heads switch with the state register
  always_comb begin
    sig_d = {4{SIG_RED}};
    ack_d = '0;
    case (state_d)
      GREEN_ST: sig_d[dir_d] = ped_flag_d ? SIG_ST_PED : SIG_ST;
      GREEN_RT: sig_d[dir_d] = SIG_RT;
      YELLOW:   sig_d[dir_d] = SIG_YEL_V;
      default:  ;
    endcase
    if (enter_st && ped_flag_d) ack_d = dir_onehot(dir_d);
  end

  // Registered signal heads and pedestrian acknowledge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sig_q <= {4{SIG_RED}};
      ack_q <= '0;
    end else begin
      sig_q <= sig_d;
      ack_q <= ack_d;
    end
  end

  assign north_sgnl_out = sig_q[DIR_N];
  assign south_sgnl_out = sig_q[DIR_S];
  assign east_sgnl_out  = sig_q[DIR_E];
  assign west_sgnl_out  = sig_q[DIR_W];
  assign active_dir     = dir_q;
  assign phase          = state_q;
  assign ped_ack        = ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: table-driven phase
// sequence, hand-written corner sequences, and randomized traffic against a
// schedule-queue reference model.
module tb_traffic_phase_scheduler;

  localparam int ST  = 10;
  localparam int RT  = 5;
  localparam int YL  = 3;
  localparam int AR  = 1;
  localparam int PER = ST + RT + YL + AR;

  localparam logic [7:0] RED = 8'h43;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] veh_req = '0, ped_req = '0, emg_req = '0;
  logic [7:0] north_sgnl_out, south_sgnl_out, east_sgnl_out, west_sgnl_out;
  logic [1:0] active_dir;
  logic [2:0] phase;
  logic [3:0] ped_ack;

  traffic_phase_scheduler #(
    .ST_TIME(ST), .RT_TIME(RT), .YEL_TIME(YL), .AR_TIME(AR), .CNT_W(8)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .veh_req(veh_req), .ped_req(ped_req), .emg_req(emg_req),
    .north_sgnl_out(north_sgnl_out), .south_sgnl_out(south_sgnl_out),
    .east_sgnl_out(east_sgnl_out), .west_sgnl_out(west_sgnl_out),
    .active_dir(active_dir), .phase(phase), .ped_ack(ped_ack)
  );

  always #5 clk_in = ~clk_in;

  logic [3:0][7:0] sig_o;
  assign sig_o = {west_sgnl_out, east_sgnl_out, south_sgnl_out, north_sgnl_out};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: a queue of upcoming head values -------
  typedef struct {logic [2:0] ph; logic [7:0] val;} slot_t;
  slot_t           mq[$];
  logic [3:0][7:0] m_sig;
  logic [2:0]      m_phase;
  logic [1:0]      m_dir;
  int              m_rr;
  logic [3:0]      m_pend, m_ack;
  bit              model_on;

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < AR - 1; k++) mq.push_back('{3'd0, RED});
    m_sig = {4{RED}}; m_phase = 3'd0; m_dir = 2'd0; m_rr = 0;
    m_pend = '0; m_ack = '0; model_on = 1'b1;
  endtask

  task automatic model_step(input logic [3:0] v, input logic [3:0] p);
    slot_t e;
    logic [3:0] cand, clr;
    logic [7:0] stv;
    logic flag;
    int w;
    m_ack = '0; clr = '0;
    if (mq.size() > 0) begin
      e = mq.pop_front();
    end else begin
      cand = v | m_pend;
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && cand[(m_rr + k) % 4]) w = (m_rr + k) % 4;
      if (w >= 0) begin
        flag = m_pend[w];
        m_dir = 2'(w);
        m_rr = (w + 1) % 4;
        clr[w] = 1'b1;
        stv = flag ? 8'hAA : 8'h6A;
        for (int k = 0; k < ST; k++) mq.push_back('{3'd1, stv});
        for (int k = 0; k < RT; k++) mq.push_back('{3'd2, 8'h71});
        for (int k = 0; k < YL; k++) mq.push_back('{3'd3, 8'h46});
        for (int k = 0; k < AR; k++) mq.push_back('{3'd0, RED});
        e = mq.pop_front();
        if (flag) m_ack[w] = 1'b1;
      end else begin
        e = '{3'd0, RED};
      end
    end
    m_pend = (m_pend & ~clr) | (p & ~m_pend);
    m_phase = e.ph;
    m_sig = {4{RED}};
    m_sig[m_dir] = e.val;
  endtask

  // One clock: drive, let the edge happen, advance model, check at negedge
  task automatic cyc(input logic [3:0] v, input logic [3:0] p, input logic [3:0] e);
    veh_req = v; ped_req = p; emg_req = e;
    @(posedge clk_in);
    if (model_on) model_step(v, p);
    @(negedge clk_in);
    if (model_on)
      chk("model", {23'd0, sig_o, phase, active_dir, ped_ack},
                   {23'd0, m_sig, m_phase, m_dir, m_ack});
  endtask

  task automatic do_reset();
    veh_req = '0; ped_req = '0; emg_req = '0;
    rst_in = 1'b1;
    model_reset();
    @(negedge clk_in); @(negedge clk_in);
    chk("reset_state", {23'd0, sig_o, phase, active_dir, ped_ack},
                       {23'd0, {4{RED}}, 3'd0, 2'd0, 4'd0});
    rst_in = 1'b0;
  endtask

  typedef struct {logic [3:0] veh; int n; logic [7:0] val; logic [2:0] ph;} vec_t;
  vec_t tbl[8];

  int         n_ent, aa_cnt, ack_cnt, other_ack, guard;
  logic [1:0] ent_dir[8];
  int         ent_cyc[8];
  logic [2:0] prev;
  logic [3:0] rv, rp, re;

  initial begin
    for (int r = 0; r < 2; r++) begin
      tbl[4*r+0] = '{4'b0001, ST, 8'h6A, 3'd1};
      tbl[4*r+1] = '{4'b0001, RT, 8'h71, 3'd2};
      tbl[4*r+2] = '{4'b0001, YL, 8'h46, 3'd3};
      tbl[4*r+3] = '{4'b0001, AR, RED,   3'd0};
    end

    // Scenario 1: north only, two full cycles from the table
    do_reset();
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < tbl[i].n; c++) begin
        cyc(tbl[i].veh, 4'd0, 4'd0);
        chk($sformatf("north_seq%0d", i), {sig_o, phase},
            {RED, RED, RED, tbl[i].val, tbl[i].ph});
      end

    // Scenario 2: all approaches requesting, order and spacing of greens
    do_reset();
    n_ent = 0; prev = 3'd0;
    for (int c = 1; c <= 4 * PER + 1; c++) begin
      cyc(4'hF, 4'd0, 4'd0);
      if (phase == 3'd1 && prev != 3'd1 && n_ent < 8) begin
        ent_dir[n_ent] = active_dir; ent_cyc[n_ent] = c; n_ent++;
      end
      prev = phase;
    end
    chk("rr_entry_count", 64'(n_ent), 64'd5);
    for (int k = 0; k < n_ent && k < 5; k++) begin
      chk($sformatf("rr_dir%0d", k), 64'(ent_dir[k]), 64'(k % 4));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(ent_cyc[k] - ent_cyc[k-1]), 64'(PER));
    end

    // Scenario 3: single pedestrian press on east with no traffic
    do_reset();
    cyc(4'd0, 4'b0100, 4'd0);
    aa_cnt = 0; ack_cnt = 0; other_ack = 0;
    for (int c = 0; c < 45; c++) begin
      cyc(4'd0, 4'd0, 4'd0);
      if (east_sgnl_out == 8'hAA) aa_cnt++;
      if (ped_ack[2]) ack_cnt++;
      if ((ped_ack & 4'b1011) != 0) other_ack++;
    end
    chk("ped_green_len", 64'(aa_cnt), 64'(ST));
    chk("ped_ack_pulses", 64'(ack_cnt), 64'd1);
    chk("ped_ack_other", 64'(other_ack), 64'd0);
    chk("ped_idle_after", {sig_o, phase, active_dir}, {{4{RED}}, 3'd0, 2'd2});

    // Scenario 4: idle indefinitely, then async reset in mid right-turn
    do_reset();
    for (int c = 0; c < 30; c++) cyc(4'd0, 4'd0, 4'd0);
    chk("idle_all_red", {sig_o, phase}, {{4{RED}}, 3'd0});
    guard = 0;
    while (phase != 3'd2 && guard < 40) begin cyc(4'b0001, 4'd0, 4'd0); guard++; end
    chk("reach_green_rt", 64'(phase), 64'd2);
    cyc(4'b0001, 4'd0, 4'd0);
    cyc(4'b0001, 4'd0, 4'd0);
    #2 rst_in = 1'b1;
    #1 chk("async_reset", {sig_o, phase, ped_ack}, {{4{RED}}, 3'd0, 4'd0});
    model_reset();
    @(negedge clk_in);

    // Scenario 5/6: emergency from west during north straight cycle 4
    do_reset();
    for (int c = 0; c < 4; c++) cyc(4'b0001, 4'd0, 4'd0);
`ifdef EMERGENCY_PREEMPT_EN
    model_on = 1'b0;
    for (int c = 0; c < YL; c++) begin
      cyc(4'b0001, 4'd0, 4'b1000);
      chk($sformatf("emg_yel%0d", c), {sig_o, phase}, {RED, RED, RED, 8'h46, 3'd3});
    end
    cyc(4'b0001, 4'd0, 4'b1000);
    chk("emg_all_red", {sig_o, phase}, {{4{RED}}, 3'd0});
    cyc(4'b0001, 4'd0, 4'b1000);
    chk("emg_west_green", {sig_o, phase, active_dir}, {8'h6A, RED, RED, RED, 3'd1, 2'd3});
`else
    for (int c = 0; c < ST - 4; c++) begin
      cyc(4'b0001, 4'd0, 4'b1000);
      chk($sformatf("noemg_st%0d", c), {sig_o, phase}, {RED, RED, RED, 8'h6A, 3'd1});
    end
    for (int c = 0; c < RT; c++) begin
      cyc(4'b0001, 4'd0, 4'b1000);
      chk($sformatf("noemg_rt%0d", c), {sig_o, phase}, {RED, RED, RED, 8'h71, 3'd2});
    end
    for (int c = 0; c < YL; c++) begin
      cyc(4'b0001, 4'd0, 4'b1000);
      chk($sformatf("noemg_yel%0d", c), {sig_o, phase}, {RED, RED, RED, 8'h46, 3'd3});
    end
`endif

    // Randomized traffic and pedestrian presses against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rv = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      rp = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
`ifdef EMERGENCY_PREEMPT_EN
      re = 4'd0;
`else
      re = 4'($urandom);
`endif
      cyc(rv, rp, re);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
